iq_accumulator: RTL and testbench
=================================

IQ_ACCUMULATOR -- requirements
Module: iq_accumulator

Interface
REQ-001 Parameter SAMPLE_W, default 16: signed width of each input I and Q sample.
REQ-002 Parameter ACC_W, default 32: signed width of each accumulated sum.
REQ-003 Parameter WIN_LEN, default 1024: number of valid samples per integration window; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 trig  input  1  start-of-window request, sampled on each rising clk edge.
REQ-007 in_valid  input  1  in_i and in_q carry a sample this cycle.
REQ-008 in_i  input  SAMPLE_W  signed I sample.
REQ-009 in_q  input  SAMPLE_W  signed Q sample.
REQ-010 accumulated_output  output  2*ACC_W  {Q sum [2*ACC_W-1:ACC_W], I sum [ACC_W-1:0]}, signed; feeds the normalizer accumulated_input.
REQ-011 stb_done  output  1  one-cycle pulse: accumulated_output updated this cycle; drives the normalizer stb_start.
REQ-012 busy  output  1  high while a window is in progress.
REQ-013 sat_flag  output  1  high if either sum saturated in the last completed window.
REQ-014 trig_drop  output  1  one-cycle pulse: trig arrived while not IDLE and was discarded.

Function
REQ-015 States: IDLE, ACCUM, DONE; the state is registered.
REQ-016 IDLE: on trig=1 -> ACCUM next cycle; internal I/Q sums and sample counter cleared to 0 on the same edge.
REQ-017 A sample presented in the same cycle as an accepted trig is not accumulated.
REQ-018 ACCUM: each cycle with in_valid=1 adds sign-extended in_i/in_q to the I/Q sums and increments the counter; in_valid=0 holds all state.
REQ-019 Addition saturates: a result above 2^(ACC_W-1)-1 clamps to that value; a result below -2^(ACC_W-1) clamps to it; any clamp sets the internal window saturation bit.
REQ-020 I and Q saturate independently; the window saturation bit is the OR of both.
REQ-021 On the edge accepting sample number WIN_LEN: state -> DONE.
REQ-022 DONE (exactly one cycle): accumulated_output loads the final sums, sat_flag loads the window saturation bit, stb_done=1; next state IDLE.
REQ-023 Latency: the edge after the last valid sample produces the registered accumulated_output and stb_done=1 in the same cycle (1-cycle latency).
REQ-024 accumulated_output and sat_flag hold their values between DONE cycles; partial sums never appear on accumulated_output.
REQ-025 busy=1 in ACCUM and DONE, 0 in IDLE.
REQ-026 trig=1 in ACCUM or DONE is ignored (window unaffected) and produces trig_drop=1 on the next cycle for one cycle per ignored trig cycle.
REQ-027 in_valid in IDLE or DONE is ignored.
REQ-028 WIN_LEN=1: ACCUM lasts until the first valid sample, then DONE.

Reset
REQ-029 rst_n=0 forces, asynchronously: state IDLE, sums 0, counter 0, accumulated_output 0, stb_done 0, busy 0, sat_flag 0, trig_drop 0.
REQ-030 Reset mid-window discards the window; no stb_done is produced; the first trig after rst_n deasserts starts a fresh window.
REQ-031 Deassertion of rst_n is synchronised to clk internally before leaving the reset condition.

Verification (WIN_LEN=4 unless stated)
REQ-032 trig, then 4 valid samples I=1,2,3,4 / Q=-1,-2,-3,-4 -> one stb_done pulse; I sum=10, Q sum=-10; accumulated_output=0xFFFFFFF6_0000000A; sat_flag=0.
REQ-033 Same window with in_valid toggling 1,0,1,0,... -> identical sums; stb_done delayed by the idle cycles only.
REQ-034 ACC_W=17, WIN_LEN=4, I=32767 each sample -> I sum clamps at 65535; sat_flag=1 in the DONE cycle; Q unaffected.
REQ-035 trig asserted twice during ACCUM -> two trig_drop pulses; sums and the stb_done timing are unchanged.
REQ-036 rst_n pulsed low after 2 of 4 samples -> all outputs 0 immediately; no stb_done; the next trig plus 4 samples yields a correct fresh sum.
REQ-037 Back-to-back: trig on the cycle after stb_done -> second window accepted; the first result holds until the second DONE.

Source files
------------

// File: rtl/iq_accumulator.sv
// iq_accumulator: integrates a fixed number of valid I/Q samples per window.
// A trig starts the window, and WIN_LEN valid samples are summed with
// saturation. The final sums are then published on accumulated_output with a
// one-cycle stb_done pulse.
//
// Parameters
//   SAMPLE_W  signed input sample width (must not exceed ACC_W)
//   ACC_W     signed accumulator width per channel
//   WIN_LEN   valid samples per window, 1..65535
// Ports
//   clk                 system clock, rising edge
//   rst_n               asynchronous active-low reset, release synchronised
//   trig                start-of-window request
//   in_valid            in_i/in_q carry a sample this cycle
//   in_i, in_q          signed samples
//   accumulated_output  {Q sum, I sum} of the last completed window
//   stb_done            one-cycle pulse when accumulated_output updates
//   busy                window in progress (ACCUM or DONE)
//   sat_flag            either sum clamped during the last completed window
//   trig_drop           one-cycle pulse per trig cycle ignored while busy
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for trig; sample inputs ignored
// ACCUM | summing valid samples until WIN_LEN have been accepted
// DONE  | one cycle; result and stb_done visible; returns to IDLE
module iq_accumulator #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32,
  parameter int WIN_LEN  = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       trig,
  input  logic                       in_valid,
  input  logic signed [SAMPLE_W-1:0] in_i,
  input  logic signed [SAMPLE_W-1:0] in_q,
  output logic [2*ACC_W-1:0]         accumulated_output,
  output logic                       stb_done,
  output logic                       busy,
  output logic                       sat_flag,
  output logic                       trig_drop
);

  localparam logic [15:0]      LAST    = 16'(WIN_LEN - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state;
  logic [ACC_W-1:0] sum_i;
  logic [ACC_W-1:0] sum_q;
  logic [15:0]      cnt;
  logic             sat_win;
  logic [1:0]       rst_sync;
  logic             rst_int_n;
  logic [ACC_W:0]   add_i;
  logic [ACC_W:0]   add_q;

  // Reset asserts immediately but releases only after two clk edges, so the
  // FSM never leaves reset on an edge that races the rst_n rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  // Returns {clamped, result}. One guard bit is enough: the sample is never
  // wider than the accumulator, so a single add cannot overflow by more.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]    acc,
                                             input logic [SAMPLE_W-1:0] smp);
    logic [ACC_W:0] wide;
    wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-SAMPLE_W){smp[SAMPLE_W-1]}}, smp};
    if (wide[ACC_W] != wide[ACC_W-1])
      return {1'b1, (wide[ACC_W] ? ACC_MIN : ACC_MAX)};
    return {1'b0, wide[ACC_W-1:0]};
  endfunction

  always_comb begin
    add_i = sat_add(sum_i, in_i);
    add_q = sat_add(sum_q, in_q);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state              <= IDLE;
      sum_i              <= '0;
      sum_q              <= '0;
      cnt                <= '0;
      sat_win            <= 1'b0;
      accumulated_output <= '0;
      stb_done           <= 1'b0;
      busy               <= 1'b0;
      sat_flag           <= 1'b0;
      trig_drop          <= 1'b0;
    end else begin
      stb_done  <= 1'b0;
      trig_drop <= trig && (state != IDLE);
      case (state)
        IDLE: begin
          if (trig) begin
            state   <= ACCUM;
            busy    <= 1'b1;
            sum_i   <= '0;
            sum_q   <= '0;
            cnt     <= '0;
            sat_win <= 1'b0;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            sum_i   <= add_i[ACC_W-1:0];
            sum_q   <= add_q[ACC_W-1:0];
            sat_win <= sat_win | add_i[ACC_W] | add_q[ACC_W];
            if (cnt == LAST) begin
              // Publish on the accepting edge so the result is already
              // valid during the single DONE cycle.
              state              <= DONE;
              accumulated_output <= {add_q[ACC_W-1:0], add_i[ACC_W-1:0]};
              sat_flag           <= sat_win | add_i[ACC_W] | add_q[ACC_W];
              stb_done           <= 1'b1;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iq_accumulator.sv
module tb_iq_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               trig;
  logic               in_valid;
  logic signed [15:0] in_i;
  logic signed [15:0] in_q;
  logic [63:0]        out_a;
  logic [33:0]        out_b;
  logic               stb_a, stb_b, busy_a, busy_b, sat_a, sat_b, drop_a, drop_b;

  // a: ACC_W=32; b: ACC_W=17 (saturation corner cases). Both WIN_LEN=4.
  iq_accumulator #(.SAMPLE_W(16), .ACC_W(32), .WIN_LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .trig(trig), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .accumulated_output(out_a), .stb_done(stb_a),
    .busy(busy_a), .sat_flag(sat_a), .trig_drop(drop_a));

  iq_accumulator #(.SAMPLE_W(16), .ACC_W(17), .WIN_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .trig(trig), .in_valid(in_valid),
    .in_i(in_i), .in_q(in_q), .accumulated_output(out_b), .stb_done(stb_b),
    .busy(busy_b), .sat_flag(sat_b), .trig_drop(drop_b));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0][15:0] si;
    logic [3:0][15:0] sq;
    int               gap;
    logic [3:0]       drops;
    bit               done_trig;
    int               ei, eq;
    bit               esat;
    int               ei17, eq17;
    bit               esat17;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [63:0] a;
    logic        a_sat;
    logic [33:0] b;
    logic        b_sat;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[7];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          drops_a = 0, drops_b = 0, exp_drops = 0;
  logic [63:0] prev_a = '0;
  logic [33:0] prev_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (drop_a) drops_a++;
    if (drop_b) drops_b++;
    if (stb_a || stb_b) begin
      if (sb.size() == 0) begin
        check("stb_unexpected", {62'b0, stb_b, stb_a}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("stb_cycle", 64'(cyc), 64'(e.cyc));
        check("stb_a", {63'b0, stb_a}, 64'd1);
        check("stb_b", {63'b0, stb_b}, 64'd1);
        check("acc_a", out_a, e.a);
        check("sat_a", {63'b0, sat_a}, {63'b0, e.a_sat});
        check("acc_b", {30'b0, out_b}, {30'b0, e.b});
        check("sat_b", {63'b0, sat_b}, {63'b0, e.b_sat});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input int i0, i1, i2, i3, q0, q1, q2, q3,
                              input int gap, input logic [3:0] drops, input bit dt,
                              input int ei, eq, input bit es,
                              input int ei17, eq17, input bit es17);
    vec_t v;
    v.si[0] = 16'(i0); v.si[1] = 16'(i1); v.si[2] = 16'(i2); v.si[3] = 16'(i3);
    v.sq[0] = 16'(q0); v.sq[1] = 16'(q1); v.sq[2] = 16'(q2); v.sq[3] = 16'(q3);
    v.gap = gap; v.drops = drops; v.done_trig = dt;
    v.ei = ei; v.eq = eq; v.esat = es;
    v.ei17 = ei17; v.eq17 = eq17; v.esat17 = es17;
    return v;
  endfunction

  // Ends one cycle into IDLE after DONE, so a following call is back-to-back.
  task automatic run_window(input vec_t v);
    exp_t e;
    trig = 1'b1; in_valid = 1'b1; in_i = 16'sd1000; in_q = -16'sd1000;
    step();
    trig = 1'b0;
    check("busy_a_accum", {63'b0, busy_a}, 64'd1);
    check("busy_b_accum", {63'b0, busy_b}, 64'd1);
    check("hold_a_start", out_a, prev_a);
    check("hold_b_start", {30'b0, out_b}, {30'b0, prev_b});
    for (int k = 0; k < 4; k++) begin
      repeat (v.gap) begin
        in_valid = 1'b0; in_i = 16'sh7777; in_q = 16'sh7777;
        step();
      end
      if (k == 2) begin
        check("hold_a_mid", out_a, prev_a);
        check("hold_b_mid", {30'b0, out_b}, {30'b0, prev_b});
      end
      in_valid = 1'b1; in_i = v.si[k]; in_q = v.sq[k]; trig = v.drops[k];
      if (k == 3) begin
        e.cyc   = cyc + 1;
        e.a     = {32'(v.eq), 32'(v.ei)};
        e.a_sat = v.esat;
        e.b     = {17'(v.eq17), 17'(v.ei17)};
        e.b_sat = v.esat17;
        sb.push_back(e);
        prev_a = e.a;
        prev_b = e.b;
      end
      step();
      trig = 1'b0;
    end
    in_valid = 1'b1; in_i = 16'sh1234; in_q = 16'sh4321; trig = v.done_trig;
    step();
    trig = 1'b0; in_valid = 1'b0;
    exp_drops += int'(v.drops[0]) + int'(v.drops[1]) + int'(v.drops[2])
               + int'(v.drops[3]) + int'(v.done_trig);
  endtask

  task automatic idle_and_check();
    in_valid = 1'b1; in_i = 16'sd3000; in_q = 16'sd3000;
    step();
    in_valid = 1'b0;
    check("busy_a_idle", {63'b0, busy_a}, 64'd0);
    check("busy_b_idle", {63'b0, busy_b}, 64'd0);
    check("drops_a", 64'(drops_a), 64'(exp_drops));
    check("drops_b", 64'(drops_b), 64'(exp_drops));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_acc_a"}, out_a, 64'd0);
    check({tag, "_acc_b"}, {30'b0, out_b}, 64'd0);
    check({tag, "_ctl_a"}, {60'b0, stb_a, busy_a, sat_a, drop_a}, 64'd0);
    check({tag, "_ctl_b"}, {60'b0, stb_b, busy_b, sat_b, drop_b}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    //            I samples                  Q samples              gap drops dt  I32      Q32     s  I17     Q17    s
    tbl[0] = mk(1, 2, 3, 4,                  -1, -2, -3, -4,          0, 4'b0000, 0, 10, -10, 0, 10, -10, 0);
    tbl[1] = mk(1, 2, 3, 4,                  -1, -2, -3, -4,          1, 4'b0000, 0, 10, -10, 0, 10, -10, 0);
    tbl[2] = mk(32767, 32767, 32767, 32767,  0, 1, -1, 5,             0, 4'b0000, 0, 131068, 5, 0, 65535, 5, 1);
    tbl[3] = mk(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768,
                                                                      0, 4'b0000, 0, -131072, -131072, 0, -65536, -65536, 1);
    tbl[4] = mk(32767, 32767, 32767, -32768, 100, -200, 300, -400,    0, 4'b0000, 0, 65533, -200, 0, 32767, -200, 1);
    tbl[5] = mk(-5, 7, 0, -2,                3, 3, 3, 3,              2, 4'b0000, 1, 0, 12, 0, 0, 12, 0);
    tbl[6] = mk(1, 2, 3, 4,                  -1, -2, -3, -4,          0, 4'b0110, 0, 10, -10, 0, 10, -10, 0);

    rst_n = 1'b0; trig = 1'b0; in_valid = 1'b0; in_i = '0; in_q = '0;
    repeat (3) step();
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) step();

    for (int n = 0; n < 7; n++) begin
      run_window(tbl[n]);
      idle_and_check();
    end

    // Back-to-back: second trig on the cycle right after stb_done.
    run_window(tbl[2]);
    run_window(tbl[3]);
    idle_and_check();

    // Reset after two accepted samples: outputs clear at once, no stb_done.
    trig = 1'b1; step(); trig = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_i = 16'sd500; in_q = 16'sd500;
      step();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    prev_a = '0; prev_b = '0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    run_window(tbl[0]);
    idle_and_check();

    repeat (4) step();
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
